// File: rtl/user_insn_dispatch.sv
// User-defined-instruction dispatcher: decodes the CPU opcode, forwards operands to one of
// NUM_UNITS execution units over req/ack, and returns the result with timeout/bad-unit errors.
module user_insn_dispatch #(
    parameter int NUM_UNITS = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    user_valid,
    input  logic [10:0]             user_opcode,
    input  logic [31:0]             user_operand_0,
    input  logic [31:0]             user_operand_1,
    output logic [31:0]             user_result,
    output logic                    user_complete,
    output logic [NUM_UNITS-1:0]    unit_req,
    output logic [7:0]              unit_op,
    output logic [31:0]             unit_a,
    output logic [31:0]             unit_b,
    input  logic [NUM_UNITS-1:0]    unit_ack,
    input  logic [NUM_UNITS*32-1:0] unit_rdata,
    output logic [1:0]              err_status,
    output logic                    err_irq_n
);

    typedef enum logic [1:0] {IDLE, REQ, RESP, WAIT_DROP} state_t;

    state_t                state_reg, state_next;
    logic [2:0]            idx_reg;
    logic [15:0]           count_reg;
    logic [1:0]            err_reg;
    logic [31:0]           result_reg;
    logic [7:0]            op_reg;
    logic [31:0]           a_reg, b_reg;

    logic [2:0]            req_idx;
    logic                  idx_ok, is_clear;
    logic [NUM_UNITS-1:0]  sel_onehot;
    logic [31:0]           rdata_masked [NUM_UNITS];
    logic [31:0]           rdata_sel;
    logic                  ack_hit, timeout_hit;

    assign req_idx  = user_opcode[10:8];
    assign idx_ok   = int'(req_idx) < NUM_UNITS;
    assign is_clear = (req_idx == 3'd7) && (user_opcode[7:0] == 8'hFF);

    // Only the latched unit's ack/rdata can reach the FSM; everything else is masked off.
    generate
        for (genvar gi = 0; gi < NUM_UNITS; gi++) begin : g_unit
            assign sel_onehot[gi]   = (idx_reg == 3'(gi));
            assign rdata_masked[gi] = unit_rdata[32*gi +: 32] & {32{sel_onehot[gi]}};
        end
    endgenerate

    always_comb begin
        rdata_sel = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            rdata_sel = rdata_sel | rdata_masked[i];
        end
    end

    assign ack_hit     = |(unit_ack & sel_onehot);
    assign timeout_hit = (count_reg == 16'(TIMEOUT - 1));

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:      if (user_valid) state_next = idx_ok ? REQ : RESP;
            REQ:       if (ack_hit || timeout_hit) state_next = RESP;
            RESP:      state_next = WAIT_DROP;
            WAIT_DROP: if (!user_valid) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            idx_reg    <= '0;
            count_reg  <= '0;
            err_reg    <= '0;
            result_reg <= '0;
            op_reg     <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (user_valid) begin
                        if (idx_ok) begin
                            idx_reg   <= req_idx;
                            op_reg    <= user_opcode[7:0];
                            a_reg     <= user_operand_0;
                            b_reg     <= user_operand_1;
                            count_reg <= '0;
                        end else if (is_clear) begin
                            result_reg <= {30'b0, err_reg};
                            err_reg    <= 2'b00;
                        end else begin
                            result_reg <= '0;
                            err_reg[1] <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    count_reg <= count_reg + 16'd1;
                    // An ack arriving on the timeout edge still counts as success.
                    if (ack_hit) begin
                        result_reg <= rdata_sel;
                    end else if (timeout_hit) begin
                        result_reg <= 32'hFFFF_FFFF;
                        err_reg[0] <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign unit_req      = (state_reg == REQ) ? sel_onehot : '0;
    assign user_complete = (state_reg == RESP);
    assign user_result   = result_reg;
    assign unit_op       = op_reg;
    assign unit_a        = a_reg;
    assign unit_b        = b_reg;
    assign err_status    = err_reg;
    assign err_irq_n     = ~|err_reg;

endmodule

// File: tb/tb_user_insn_dispatch.sv
// Directed bench for user_insn_dispatch: dispatch, timeout, bad unit, status clear,
// held-valid protection and reset during an outstanding request.
module tb_user_insn_dispatch;

    logic         clk = 1'b0;
    logic         rst;
    logic         user_valid;
    logic [10:0]  user_opcode;
    logic [31:0]  user_operand_0, user_operand_1;
    logic [31:0]  user_result;
    logic         user_complete;
    logic [3:0]   unit_req;
    logic [7:0]   unit_op;
    logic [31:0]  unit_a, unit_b;
    logic [3:0]   unit_ack;
    logic [127:0] unit_rdata;
    logic [1:0]   err_status;
    logic         err_irq_n;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    user_insn_dispatch #(.NUM_UNITS(4), .TIMEOUT(255)) dut (
        .clk            (clk),
        .rst            (rst),
        .user_valid     (user_valid),
        .user_opcode    (user_opcode),
        .user_operand_0 (user_operand_0),
        .user_operand_1 (user_operand_1),
        .user_result    (user_result),
        .user_complete  (user_complete),
        .unit_req       (unit_req),
        .unit_op        (unit_op),
        .unit_a         (unit_a),
        .unit_b         (unit_b),
        .unit_ack       (unit_ack),
        .unit_rdata     (unit_rdata),
        .err_status     (err_status),
        .err_irq_n      (err_irq_n)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [10:0] op, input logic [31:0] a, input logic [31:0] b);
        user_opcode    = op;
        user_operand_0 = a;
        user_operand_1 = b;
        user_valid     = 1'b1;
        tick();
    endtask

    task automatic release_valid();
        user_valid = 1'b0;
        tick();
        tick();
    endtask

    int cyc, n_comp, n_req;

    initial begin
        rst = 1'b1; user_valid = 1'b0; user_opcode = '0;
        user_operand_0 = '0; user_operand_1 = '0; unit_ack = '0; unit_rdata = '0;
        tick(); tick();
        chk("rst_req",    32'(unit_req), 32'h0);
        chk("rst_comp",   32'(user_complete), 32'h0);
        chk("rst_err",    32'(err_status), 32'h0);
        chk("rst_irq_n",  32'(err_irq_n), 32'h1);
        chk("rst_result", user_result, 32'h0);
        chk("rst_op",     32'(unit_op), 32'h0);
        rst = 1'b0;
        tick();

        // Unit 1 acks on its second request cycle.
        issue(11'h105, 32'd3, 32'd4);
        chk("t1_req_c1", 32'(unit_req), 32'h2);
        chk("t1_op",     32'(unit_op), 32'h05);
        chk("t1_a",      unit_a, 32'd3);
        chk("t1_b",      unit_b, 32'd4);
        chk("t1_comp0",  32'(user_complete), 32'h0);
        tick();
        chk("t1_req_c2", 32'(unit_req), 32'h2);
        unit_ack = 4'b0010; unit_rdata[63:32] = 32'h7;
        tick();
        unit_ack = '0;
        chk("t1_comp",   32'(user_complete), 32'h1);
        chk("t1_result", user_result, 32'h7);
        chk("t1_req_off", 32'(unit_req), 32'h0);
        chk("t1_err",    32'(err_status), 32'h0);
        tick();
        chk("t1_comp_1cyc", 32'(user_complete), 32'h0);
        release_valid();

        // Unit 2 never acks: 255 request cycles then timeout.
        issue(11'h200, 32'h0, 32'h0);
        cyc = 0;
        while (unit_req == 4'b0100 && cyc < 300) begin
            cyc++;
            tick();
        end
        chk("t2_req_cycles", 32'(cyc), 32'd255);
        chk("t2_comp",   32'(user_complete), 32'h1);
        chk("t2_result", user_result, 32'hFFFF_FFFF);
        chk("t2_err",    32'(err_status), 32'h1);
        chk("t2_irq_n",  32'(err_irq_n), 32'h0);
        release_valid();

        // Bad unit index 5.
        issue(11'h500, 32'h0, 32'h0);
        chk("t3_comp",   32'(user_complete), 32'h1);
        chk("t3_result", user_result, 32'h0);
        chk("t3_err",    32'(err_status), 32'h3);
        chk("t3_req",    32'(unit_req), 32'h0);
        release_valid();

        // Status clear returns the old status and clears it.
        issue(11'h7FF, 32'h0, 32'h0);
        chk("t4_comp",   32'(user_complete), 32'h1);
        chk("t4_result", user_result, 32'h3);
        chk("t4_err",    32'(err_status), 32'h0);
        chk("t4_irq_n",  32'(err_irq_n), 32'h1);
        release_valid();

        // Unit 3 selected; unit 0 acks throughout and must be ignored.
        unit_rdata[31:0] = 32'hDEAD_BEEF; unit_rdata[127:96] = 32'h33;
        issue(11'h312, 32'h11, 32'h22);
        chk("t5_req", 32'(unit_req), 32'h8);
        unit_ack = 4'b0001;
        tick();
        chk("t5_ignore_req",  32'(unit_req), 32'h8);
        chk("t5_ignore_comp", 32'(user_complete), 32'h0);
        unit_ack = 4'b1001;
        tick();
        unit_ack = 4'b0001;
        chk("t5_comp",   32'(user_complete), 32'h1);
        chk("t5_result", user_result, 32'h33);
        n_comp = 0; n_req = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (user_complete) n_comp++;
            if (unit_req != 4'b0000) n_req++;
        end
        chk("t5_hold_comp", 32'(n_comp), 32'd0);
        chk("t5_hold_req",  32'(n_req), 32'd0);
        chk("t5_hold_result", user_result, 32'h33);
        unit_ack = '0;
        release_valid();

        // Reset on the third request cycle: request drops with no completion.
        issue(11'h101, 32'h5, 32'h6);
        tick(); tick();
        chk("t6_req_c3", 32'(unit_req), 32'h2);
        rst = 1'b1; user_valid = 1'b0;
        tick();
        chk("t6_req_off", 32'(unit_req), 32'h0);
        chk("t6_comp",    32'(user_complete), 32'h0);
        chk("t6_err",     32'(err_status), 32'h0);
        rst = 1'b0;
        tick();
        unit_ack = 4'b0010; unit_rdata[63:32] = 32'hABC;
        issue(11'h102, 32'h1, 32'h2);
        chk("t6_redo_req", 32'(unit_req), 32'h2);
        tick();
        unit_ack = '0;
        chk("t6_redo_comp",   32'(user_complete), 32'h1);
        chk("t6_redo_result", user_result, 32'hABC);
        release_valid();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/user_insn_dispatch.md
Name: user_insn_dispatch

Overview:
- Sequences the CPU user-defined-instruction port and shares it among up to NUM_UNITS execution units.
- Decodes user_opcode into a unit index and a sub-op, then forwards the operands over a req/ack handshake.
- Returns the unit's result with a single-cycle user_complete.
- Adds a no-ack timeout, a bad-unit error, sticky error status, and an active-low error interrupt that can be wired into interrupt_n.

Parameters:
- NUM_UNITS, 4: number of attached execution units (1..7); unit index 7 is reserved.
- TIMEOUT, 255: maximum cycles unit_req is held without unit_ack (1..65535).

Ports:
- clk  in  1  core clock (clk_kdf9 domain)
- rst  in  1  synchronous, active-high reset
- user_valid  in  1  CPU instruction request; held high until user_complete
- user_opcode  in  11  [10:8] unit index, [7:0] sub-op
- user_operand_0  in  32  operand A
- user_operand_1  in  32  operand B
- user_result  out  32  result returned to the CPU
- user_complete  out  1  one-cycle completion pulse to the CPU
- unit_req  out  NUM_UNITS  one-hot request to the selected unit
- unit_op  out  8  registered sub-op
- unit_a  out  32  registered operand A
- unit_b  out  32  registered operand B
- unit_ack  in  NUM_UNITS  per-unit acknowledge; result valid in the same cycle
- unit_rdata  in  NUM_UNITS*32  per-unit result; unit i occupies bits [32i+31:32i]
- err_status  out  2  sticky errors: bit0 = timeout, bit1 = bad unit
- err_irq_n  out  1  active-low error interrupt, equal to ~|err_status

Behaviour:
- Reset (rst high at a clk edge, from any state):
  - state goes to IDLE.
  - unit_req, user_complete, err_status, the timeout counter, unit_op, unit_a and unit_b all go to 0.
  - user_result goes to 0; err_irq_n goes to 1.
  - A reset during REQ drops unit_req on the next edge with no completion.
- FSM states: IDLE, REQ, RESP, WAIT_DROP.
- IDLE, when user_valid=1 at an edge, with idx = user_opcode[10:8]:
  - idx < NUM_UNITS: latch op, A and B; enter REQ; unit_req[idx]=1 from the next cycle.
  - idx=7 and sub-op=8'hFF (status clear): set user_result={30'b0,err_status}, clear err_status, enter RESP.
  - Any other idx >= NUM_UNITS: set user_result=0, set err_status[1], enter RESP.
- REQ:
  - unit_req[idx] is held high and the counter increments each cycle.
  - If unit_ack[idx]=1: capture unit_rdata slice idx into user_result, drop unit_req, enter RESP.
  - Else if the counter reaches TIMEOUT-1: set user_result=32'hFFFF_FFFF, set err_status[0], drop unit_req, enter RESP.
  - An ack on the same edge as the timeout wins; no error is flagged.
  - Acks from non-selected units are ignored at all times, and unit_ack in any state other than REQ is ignored.
- RESP: user_complete=1 for exactly one cycle with user_result stable; next state is WAIT_DROP.
- WAIT_DROP: stays until user_valid=0, then goes to IDLE. This prevents re-issue while the CPU still holds user_valid.
- user_result holds its last value until the next capture.
- Latency:
  - user_valid sampled at edge N gives unit_req at cycle N+1.
  - unit_ack at cycle M gives user_complete at cycle M+1.
  - Minimum total is 3 cycles from valid to complete.
  - Bad-unit and clear requests complete in 2 cycles.
- err_status bits are sticky and set independently. Clearing happens only through the clear opcode or rst. A set and a clear in the same cycle cannot occur because the FSM is serial.
- Counter is 16 bits and is zeroed on entry to REQ.

Test Plan:
- Opcode 11'h105, A=3, B=4; unit1 acks after 2 cycles of unit_req with rdata=32'h7 -> unit_req=4'b0010 for 2 cycles, unit_op=8'h05, user_complete one cycle later with user_result=7, err_status=0.
- Opcode 11'h200; unit2 never acks; TIMEOUT=255 -> unit_req high exactly 255 cycles, then user_complete with result 32'hFFFF_FFFF, err_status=2'b01, err_irq_n=0.
- Opcode 11'h500 (idx 5 >= NUM_UNITS) -> user_complete 2 cycles after valid, result 0, err_status=2'b11 following the previous test, no unit_req.
- Opcode 11'h7FF -> user_result=32'h3, err_status=0, err_irq_n=1.
- user_valid held 10 cycles after complete, with acks from unit0 while unit3 is selected -> no second dispatch until valid drops, and unit0 acks have no effect.
- rst asserted on the 3rd cycle of REQ -> unit_req=0 on the next edge, no user_complete, err_status=0; the next instruction dispatches normally.
